if_fetch_unit: RTL

Instruction-fetch stage of the MIPS32 pipeline: owns the fetch PC, issues word requests to instruction memory over a req/ack handshake, buffers returned instructions in a small queue, and presents them with their PC+4 to the IF/ID pipeline register. It is the producer side of the IF/ID interface. It consumes the IF/ID write enable as its downstream-ready signal and accepts branch/jump redirects from later stages.

---
 rtl/if_pkg.sv | 17 +
 rtl/if_fetch_unit_fetch_queue.sv | 59 +++++
 rtl/if_fetch_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// if_pkg : shared constants and state encoding for the fetch stage | rev 1.0
// ============================================================================
package if_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_INC    = 32'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : synchronous FIFO of {instruction, pc+4}, clear dominant | rev 1.0
// ============================================================================
module fetch_queue #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   input  logic                         clear,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [WIDTH-1:0]             head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_pop;

   // DEPTH is a power of two, so pointers wrap naturally.
   assign do_pop = pop && (count != '0);
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear)
         mem[wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// if_fetch_unit : MIPS32 fetch PC, imem req/ack and IF/ID producer | rev 1.0
// ============================================================================
module if_fetch_unit
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          FQ_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        id_wen,
   output logic [31:0] IF_Instruction,
   output logic [31:0] IF_PC_p4,
   output logic        IF_valid
);

   localparam int              CW      = $clog2(FQ_DEPTH+1);
   localparam logic [CW:0]     DEPTH_W = (CW+1)'(FQ_DEPTH);

   fetch_state_t  state, next_state;
   logic [31:0]   fetch_pc;
   logic [31:0]   hold_pc;
   logic [31:0]   redirect_aligned;
   logic          q_push, q_pop;
   logic [CW-1:0] q_count;
   logic [63:0]   q_head;
   logic [CW:0]   proj_count;
   logic          room;
   logic          unused_pc_bits;

   assign redirect_aligned = {redirect_pc[31:2], 2'b00};
   assign unused_pc_bits   = ^redirect_pc[1:0];

   // A redirect overrides both push and pop; the clear wipes the queue anyway.
   assign q_push     = (state == REQ) && imem_ack && !redirect;
   assign q_pop      = id_wen && IF_valid && !redirect;
   assign proj_count = {1'b0, q_count} + {{CW{1'b0}}, q_push} - {{CW{1'b0}}, q_pop};
   assign room       = proj_count < DEPTH_W;

   fetch_queue #(
      .WIDTH (64),
      .DEPTH (FQ_DEPTH)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (q_push),
      .push_data ({imem_rdata, fetch_pc + PC_INC}),
      .pop       (q_pop),
      .clear     (redirect),
      .count     (q_count),
      .head      (q_head)
   );

   always_ff @(posedge clk) begin
      if (!reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (redirect || room)
               next_state = REQ;
         end
         REQ: begin
            if (redirect)
               next_state = imem_ack ? REQ : DROP;
            else if (imem_ack)
               next_state = room ? REQ : IDLE;
         end
         DROP: begin
            if (imem_ack)
               next_state = REQ;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      imem_req  = 1'b0;
      imem_addr = fetch_pc;
      case (state)
         REQ:  imem_req = 1'b1;
         DROP: begin
            imem_req  = 1'b1;
            imem_addr = hold_pc;
         end
         default: ;
      endcase
   end

   // hold_pc keeps the abandoned address stable until memory completes it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_pc <= RESET_PC;
         hold_pc  <= RESET_PC;
      end else begin
         if (redirect && (state == REQ) && !imem_ack)
            hold_pc <= fetch_pc;
         if (redirect)
            fetch_pc <= redirect_aligned;
         else if (q_push)
            fetch_pc <= fetch_pc + PC_INC;
      end
   end

   assign IF_valid       = (q_count != '0);
   assign IF_Instruction = IF_valid ? q_head[63:32] : NOP_INSTR;
   assign IF_PC_p4       = IF_valid ? q_head[31:0]  : 32'h0;

endmodule
`default_nettype wire
